// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- rv32i writeback stage, directly upstream of the register file.
//
// Accepts one retired result per handshake from execute. Non-loads are written
// to the register file on the following cycle. Loads wait in LOAD_WAIT for the
// data-memory response, are size/sign-extended from the aligned 32-bit word,
// and then written. Illegal funct3, misaligned addresses and response timeouts
// raise a one-cycle exception pulse toward the trap logic.
//
// Parameters:
//   LOAD_TIMEOUT  LOAD_WAIT cycles without a response before a timeout (>=2)
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_valid / o_ready         execute handshake (o_ready = state is IDLE)
//   i_rd, i_result            destination register, ALU result or load address
//   i_is_load, i_funct3       load flag and load size/sign encoding
//   i_mem_rvalid, i_mem_rdata data-memory response (aligned word)
//   o_wen, o_waddr, o_wdata   register file write port (registered)
//   o_exc, o_exc_cause        exception pulse: 01 misaligned, 10 illegal
//                             funct3, 11 load timeout
//
// Optional build macro WB_FWD_EN adds decode bypass/interlock outputs:
//   o_fwd_valid/o_fwd_rd/o_fwd_data  copies of o_wen/o_waddr/o_wdata
//   o_ld_pend                        a load is waiting for data
//   o_ld_rd                          rd of the pending load, 0 otherwise
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_result,
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_wdata,
  output logic [4:0]  o_waddr,
  output logic        o_wen,
  output logic        o_exc,
  output logic [1:0]  o_exc_cause
`ifdef WB_FWD_EN
  ,
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_rd,
  output logic [31:0] o_fwd_data,
  output logic        o_ld_pend,
  output logic [4:0]  o_ld_rd
`endif
);

  // The counter only ever reaches LOAD_TIMEOUT-1.
  localparam int CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        rd_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              wen_q;
  logic [4:0]        waddr_q;
  logic [31:0]       wdata_q;
  logic              exc_q;
  logic [1:0]        cause_q;
  logic [31:0]       ld_data_d;

  // Encodings 011, 110, 111 are not rv32i loads.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Only meaningful for legal encodings: bits [1:0] select byte/half/word.
  function automatic logic addr_misaligned(input logic [2:0] f3,
                                           input logic [1:0] addr);
    return ((f3[1:0] == 2'b01) && addr[0]) ||
           ((f3[1:0] == 2'b10) && (addr != 2'b00));
  endfunction

  // Select the addressed byte/halfword lane and extend per funct3.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  assign ld_data_d = load_extract(f3_q, off_q, i_mem_rdata);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      exc_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      // Write and exception strobes are single-cycle pulses.
      wen_q   <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (!i_is_load) begin
              // x0 is never written, but the result is still retired.
              if (i_rd != 5'd0) begin
                wen_q   <= 1'b1;
                waddr_q <= i_rd;
                wdata_q <= i_result;
              end
            end else if (f3_illegal(i_funct3)) begin
              exc_q   <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end else if (addr_misaligned(i_funct3, i_result[1:0])) begin
              exc_q   <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              rd_q    <= i_rd;
              f3_q    <= i_funct3;
              off_q   <= i_result[1:0];
              cnt_q   <= '0;
              state_q <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          // A response in the final count cycle beats the timeout.
          if (i_mem_rvalid) begin
            if (rd_q != 5'd0) begin
              wen_q   <= 1'b1;
              waddr_q <= rd_q;
              wdata_q <= ld_data_d;
            end
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            exc_q   <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_wen       = wen_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_exc       = exc_q;
  assign o_exc_cause = cause_q;

`ifdef WB_FWD_EN
  assign o_fwd_valid = wen_q;
  assign o_fwd_rd    = waddr_q;
  assign o_fwd_data  = wdata_q;
  assign o_ld_pend   = (state_q == LOAD_WAIT);
  assign o_ld_rd     = (state_q == LOAD_WAIT) ? rd_q : 5'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [4:0]  rd;
  logic [31:0] result;
  logic        is_load;
  logic [2:0]  funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wen;
  logic        exc;
  logic [1:0]  cause;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        ld_pend;
  logic [4:0]  ld_rd;
`endif

  wb_stage #(.LOAD_TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_rd         (rd),
    .i_result     (result),
    .i_is_load    (is_load),
    .i_funct3     (funct3),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_wdata      (wdata),
    .o_waddr      (waddr),
    .o_wen        (wen),
    .o_exc        (exc),
    .o_exc_cause  (cause)
`ifdef WB_FWD_EN
    ,
    .o_fwd_valid  (fwd_valid),
    .o_fwd_rd     (fwd_rd),
    .o_fwd_data   (fwd_data),
    .o_ld_pend    (ld_pend),
    .o_ld_rd      (ld_rd)
`endif
  );

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.wen = 1'b1; e.addr = a; e.data = d; e.cause = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_exc(input int c, input logic [1:0] cs);
    exp_t e;
    e.cyc = c; e.wen = 1'b0; e.addr = '0; e.data = '0; e.cause = cs;
    exp_q.push_back(e);
  endtask

  // Present one result for a single accept edge.
  task automatic issue(input logic [4:0] r, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3);
    valid = 1'b1; rd = r; result = res; is_load = ld; funct3 = f3;
    tick();
    valid = 1'b0; is_load = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  // Monitor: every write or exception the DUT presents must match the head of
  // the expectation queue, including the cycle it appears in.
  always @(negedge clk) begin
    if (wen && exc) begin
      total++; bad++;
      $display("FAIL wen_exc_both: wen=%b exc=%b expected not both", wen, exc);
    end
    if (!exc && cause != 2'b00) begin
      total++; bad++;
      $display("FAIL idle_cause: got %b expected 00", cause);
    end
    if (wen || exc) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: wen=%b addr=%h data=%h exc=%b cause=%b expected none",
                 wen, waddr, wdata, exc, cause);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_wen", {31'd0, wen}, {31'd0, e.wen});
        chk("event_cause", {30'd0, cause}, {30'd0, e.cause});
        if (e.wen) begin
          chk("event_waddr", {27'd0, waddr}, {27'd0, e.addr});
          chk("event_wdata", wdata, e.data);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0; rd = '0; result = '0; is_load = 1'b0;
    funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_wen",   {31'd0, wen},   32'd0);
    chk("rst_exc",   {31'd0, exc},   32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata,          32'd0);

    // Back-to-back non-loads
    push_wr(cyc + 1, 5'h12, 32'hdeadbeef);
    issue(5'h12, 32'hdeadbeef, 1'b0, 3'b000);
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    push_wr(cyc + 1, 5'h13, 32'hbabecafe);
    issue(5'h13, 32'hbabecafe, 1'b0, 3'b000);
    chk("b2b_ready2", {31'd0, ready}, 32'd1);

    // x0 write suppressed, no event expected
    issue(5'd0, 32'hbbc0ffee, 1'b0, 3'b000);
    tick();

    // Response while idle is ignored
    respond(32'h55555555);
    tick();

    // LB at byte 3, response three cycles after accept
    n = cyc;
    issue(5'd1, 32'h00001003, 1'b1, 3'b000);
    tick();
    chk("lb_wait_ready", {31'd0, ready}, 32'd0);
`ifdef WB_FWD_EN
    chk("lb_ld_pend", {31'd0, ld_pend}, 32'd1);
    chk("lb_ld_rd", {27'd0, ld_rd}, 32'd1);
`endif
    tick();
    push_wr(n + 4, 5'd1, 32'hffffff80);
    respond(32'h80ffffff);
    chk("lb_ready_after", {31'd0, ready}, 32'd1);

    // LBU same lane
    n = cyc;
    issue(5'd2, 32'h00001003, 1'b1, 3'b100);
    tick(); tick();
    push_wr(n + 4, 5'd2, 32'h00000080);
    respond(32'h80ffffff);

    // LHU upper half
    issue(5'd3, 32'h00002002, 1'b1, 3'b101);
    push_wr(cyc + 1, 5'd3, 32'h0000beef);
    respond(32'hbeef1234);

    // LH lower half, sign-extended
    issue(5'd4, 32'h00002000, 1'b1, 3'b001);
    push_wr(cyc + 1, 5'd4, 32'hffff8001);
    respond(32'h12348001);

    // LW aligned
    issue(5'd5, 32'h00000004, 1'b1, 3'b010);
    push_wr(cyc + 1, 5'd5, 32'hcafef00d);
    respond(32'hcafef00d);

    // Exceptions
    push_exc(cyc + 1, 2'b01);
    issue(5'd6, 32'h00000002, 1'b1, 3'b010);
    chk("misalign_ready", {31'd0, ready}, 32'd1);
    push_exc(cyc + 1, 2'b10);
    issue(5'd6, 32'h00000000, 1'b1, 3'b011);
    push_exc(cyc + 1, 2'b10);
    issue(5'd6, 32'h00000001, 1'b1, 3'b111);
    push_exc(cyc + 1, 2'b01);
    issue(5'd6, 32'h00000001, 1'b1, 3'b101);
    tick();

    // Timeout: exception 16 cycles after entering LOAD_WAIT
    n = cyc;
    push_exc(n + 17, 2'b11);
    issue(5'd7, 32'h00000100, 1'b1, 3'b010);
    repeat (15) tick();
    chk("to_ready_last", {31'd0, ready}, 32'd0);
    tick();
    chk("to_ready_after", {31'd0, ready}, 32'd1);
    tick();

    // Response in final count cycle wins over timeout
    n = cyc;
    issue(5'd8, 32'h00000200, 1'b1, 3'b010);
    repeat (15) tick();
    push_wr(n + 17, 5'd8, 32'h11223344);
    respond(32'h11223344);
    chk("late_ready", {31'd0, ready}, 32'd1);
    tick();

    // Reset during LOAD_WAIT abandons the load
    issue(5'd9, 32'h00000300, 1'b1, 3'b010);
    tick();
`ifdef WB_FWD_EN
    chk("rstw_ld_rd", {27'd0, ld_rd}, 32'd9);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    respond(32'hffffffff);
    tick();
    chk("rstw_ready", {31'd0, ready}, 32'd1);
    chk("rstw_waddr", {27'd0, waddr}, 32'd0);
    chk("rstw_wdata", wdata, 32'd0);
    chk("rstw_wen", {31'd0, wen}, 32'd0);
`ifdef WB_FWD_EN
    chk("rstw_ld_pend", {31'd0, ld_pend}, 32'd0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
